// File: rtl/serial_compare_pkg.sv
// Shared types and helpers for the serial compare feeder and its comparator interface.
package serial_compare_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef struct packed {
        logic less;
        logic eq;
        logic greater;
        logic error;
    } cmp_result_t;

    localparam cmp_result_t CMP_RESULT_RESET = '{less: 1'b0, eq: 1'b1, greater: 1'b0, error: 1'b0};

    // True when exactly one of the three verdict flags is set.
    function automatic logic is_onehot3(input logic l, input logic e, input logic g);
        logic [2:0] v;
        v = {l, e, g};
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

endpackage

// File: rtl/msb_first_shift_reg.sv
// Parallel-load, shift-left register exposing its MSB; zero fill on shift.
module msb_first_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] data_q;

    // Load has priority over shift so an accept always starts from fresh data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end else if (shift_i) begin
            data_q <= {data_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb_o = data_q[WIDTH-1];

endmodule

// File: rtl/serial_compare_feeder.sv
// Feeds a word pair MSB first into a serial comparator and captures its verdict on the last bit.
module serial_compare_feeder
    import serial_compare_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             abort,
    output logic             ser_valid,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_first,
    output logic             ser_last,
    output logic             cmp_clear,
    input  logic             cmp_less,
    input  logic             cmp_eq,
    input  logic             cmp_greater,
    output logic             res_valid,
    output logic             res_less,
    output logic             res_eq,
    output logic             res_greater,
    output logic             res_error
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    cmp_result_t res_q, res_d;
    logic        res_valid_q, res_valid_d;
    logic        load_s;
    logic        shift_s;
    logic        msb_a_s;
    logic        msb_b_s;
    logic        last_s;

    assign last_s = (cnt_q == '0);

    // Next-state, counter and verdict capture; abort beats the last-bit capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_s  = 1'b1;
                    cnt_d   = CNT_TOP;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                shift_s = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (last_s) begin
                    res_d.less    = cmp_less;
                    res_d.eq      = cmp_eq;
                    res_d.greater = cmp_greater;
                    res_d.error   = ~is_onehot3(cmp_less, cmp_eq, cmp_greater);
                    res_valid_d   = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            res_q       <= CMP_RESULT_RESET;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    msb_first_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (load_s),
        .shift_i (shift_s),
        .data_i  (in_a),
        .msb_o   (msb_a_s)
    );

    msb_first_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (load_s),
        .shift_i (shift_s),
        .data_i  (in_b),
        .msb_o   (msb_b_s)
    );

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign in_ready    = (state_q == IDLE);
    assign cmp_clear   = (state_q == IDLE);
    assign ser_valid   = (state_q == SHIFT);
    assign ser_a       = ser_valid & msb_a_s;
    assign ser_b       = ser_valid & msb_b_s;
    assign ser_first   = ser_valid & (cnt_q == CNT_TOP);
    assign ser_last    = ser_valid & last_s;
    assign res_valid   = res_valid_q;
    assign res_less    = res_q.less;
    assign res_eq      = res_q.eq;
    assign res_greater = res_q.greater;
    assign res_error   = res_q.error;

endmodule

// File: tb/tb_serial_compare_feeder.sv
// Directed bench for serial_compare_feeder with an attached MSB-first comparator model.
module tb_serial_compare_feeder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       abort;
    logic       ser_valid, ser_a, ser_b, ser_first, ser_last, cmp_clear;
    logic       cmp_less, cmp_eq, cmp_greater;
    logic       res_valid, res_less, res_eq, res_greater, res_error;

    int checks = 0;
    int errors = 0;

    logic [1:0] m_st;
    logic       force_err;

    serial_compare_feeder #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .abort       (abort),
        .ser_valid   (ser_valid),
        .ser_a       (ser_a),
        .ser_b       (ser_b),
        .ser_first   (ser_first),
        .ser_last    (ser_last),
        .cmp_clear   (cmp_clear),
        .cmp_less    (cmp_less),
        .cmp_eq      (cmp_eq),
        .cmp_greater (cmp_greater),
        .res_valid   (res_valid),
        .res_less    (res_less),
        .res_eq      (res_eq),
        .res_greater (res_greater),
        .res_error   (res_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference comparator: m_st 0 = equal so far, 1 = less, 2 = greater.
    always_comb begin
        cmp_less    = 1'b0;
        cmp_eq      = 1'b0;
        cmp_greater = 1'b0;
        if (force_err) begin
            cmp_eq      = 1'b1;
            cmp_greater = 1'b1;
        end else if (m_st == 2'd1) begin
            cmp_less = 1'b1;
        end else if (m_st == 2'd2) begin
            cmp_greater = 1'b1;
        end else if (ser_valid) begin
            cmp_less    = ~ser_a & ser_b;
            cmp_greater = ser_a & ~ser_b;
            cmp_eq      = (ser_a == ser_b);
        end else begin
            cmp_eq = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st <= 2'd0;
        end else if (cmp_clear) begin
            m_st <= 2'd0;
        end else if (ser_valid) begin
            m_st <= cmp_greater ? 2'd2 : (cmp_less ? 2'd1 : 2'd0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One word: abort_k = 1..8 aborts in that bit cycle, 0 = none; exp_flags = {less,eq,greater,error}.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input int abort_k,
                        input bit inject_err, input logic [3:0] exp_flags);
        bit aborted;
        aborted = 1'b0;
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1;
        check("ready_at_T", in_ready, 1'b1);
        check("clear_at_T", cmp_clear, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            if (!aborted) begin
                @(negedge clk);
                in_valid = 1'b0;
                check("ser_valid", ser_valid, 1'b1);
                check("ser_a", ser_a, a[8-k]);
                check("ser_b", ser_b, b[8-k]);
                check("ser_first", ser_first, (k == 1));
                check("ser_last", ser_last, (k == 8));
                check("clear_shift", cmp_clear, 1'b0);
                check("ready_shift", in_ready, 1'b0);
                if (k == abort_k) begin
                    abort = 1'b1;
                    aborted = 1'b1;
                end
                if (inject_err && k == 8) force_err = 1'b1;
            end
        end
        @(negedge clk);
        abort = 1'b0;
        force_err = 1'b0;
        check("ser_valid_after", ser_valid, 1'b0);
        check("clear_after", cmp_clear, 1'b1);
        check("ready_after", in_ready, 1'b1);
        check("res_valid", res_valid, !aborted);
        check("res_flags", {res_less, res_eq, res_greater, res_error}, exp_flags);
        @(negedge clk);
        check("res_valid_drop", res_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
        abort = 1'b0; force_err = 1'b0;
        #12;
        check("rst_ready", in_ready, 1'b1);
        check("rst_clear", cmp_clear, 1'b1);
        check("rst_ser", {ser_valid, ser_a, ser_b, ser_first, ser_last}, 5'b00000);
        check("rst_res", {res_valid, res_less, res_eq, res_greater, res_error}, 5'b00100);
        @(negedge clk);
        rst = 1'b1;
        // abort while idle must be ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort", {in_ready, ser_valid, res_valid}, 3'b100);

        send(8'hA5, 8'hA5, 0, 1'b0, 4'b0100);
        send(8'h80, 8'h7F, 0, 1'b0, 4'b0010);
        send(8'h3C, 8'h3D, 0, 1'b0, 4'b1000);

        // Back-to-back pairs with in_valid held high.
        @(negedge clk);
        in_a = 8'h12; in_b = 8'h34; in_valid = 1'b1;
        for (int c = 0; c <= 18; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) begin in_a = 8'hF0; in_b = 8'h0F; end
            if (c == 10) in_valid = 1'b0;
            check("b2b_ready", in_ready, (c == 0 || c == 9 || c == 18));
            check("b2b_res_valid", res_valid, (c == 9 || c == 18));
            check("b2b_first", ser_first, (c == 1 || c == 10));
            if (c == 9)  check("b2b_res1", {res_less, res_eq, res_greater, res_error}, 4'b1000);
            if (c == 18) check("b2b_res2", {res_less, res_eq, res_greater, res_error}, 4'b0010);
        end

        // Aborts keep the previous verdict (greater).
        send(8'h01, 8'h02, 4, 1'b0, 4'b0010);
        send(8'h01, 8'h02, 8, 1'b0, 4'b0010);

        // Async reset in the third bit cycle.
        @(negedge clk);
        in_a = 8'h0F; in_b = 8'hF0; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_shift", ser_valid, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_ready", in_ready, 1'b1);
        check("mid_rst_clear", cmp_clear, 1'b1);
        check("mid_rst_ser", {ser_valid, ser_a, ser_b, ser_first, ser_last}, 5'b00000);
        check("mid_rst_res", {res_valid, res_less, res_eq, res_greater, res_error}, 5'b00100);
        @(negedge clk);
        rst = 1'b1;
        send(8'h55, 8'h54, 0, 1'b0, 4'b0010);

        // Non-one-hot flags on the LSB, then a clean word.
        send(8'h11, 8'h11, 0, 1'b1, 4'b0111);
        send(8'h22, 8'h22, 0, 1'b0, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_compare_feeder.md
# serial_compare_feeder

Upstream driver for the MSB-first serial comparator. It accepts a pair of WIDTH-bit words over a valid/ready handshake and streams both MSB first, one bit pair per cycle. It holds the comparator in reset between words, then captures the comparator's verdict flags on the last bit and presents them as a one-cycle registered result.

## Interface
- `WIDTH`, default 8: word width; legal range ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `in_valid` in 1: the word pair on `in_a`/`in_b` is valid.
- `in_ready` out 1: the block can accept a pair; high only in IDLE.
- `in_a`, `in_b` in WIDTH: words to compare.
- `abort` in 1: synchronous cancel of the word in flight.
- `ser_valid` out 1: high during each bit cycle.
- `ser_a`, `ser_b` out 1: current bit pair, MSB first; 0 when `ser_valid`=0.
- `ser_first`, `ser_last` out 1: mark the MSB cycle and the LSB cycle.
- `cmp_clear` out 1: active-high synchronous reset for the comparator.
- `cmp_less`, `cmp_eq`, `cmp_greater` in 1: comparator flags; valid in the same cycle as the current bit.
- `res_valid` out 1: one-cycle result strobe.
- `res_less`, `res_eq`, `res_greater` out 1: captured verdict.
- `res_error` out 1: the captured flags were not exactly one-hot.

## Operation
- States: IDLE, SHIFT.
- IDLE:
  - `in_ready`=1, `cmp_clear`=1, `ser_*`=0.
  - On `in_valid && in_ready`: load `in_a`/`in_b` into two shift registers, set the bit counter to WIDTH-1, and go to SHIFT.
- SHIFT:
  - `cmp_clear`=0, `ser_valid`=1.
  - `ser_a`/`ser_b` are the MSBs of the shift registers.
  - Each cycle, shift left with 0 fill and decrement the counter.
  - `ser_first` = (counter == WIDTH-1); `ser_last` = (counter == 0).
- Last bit (`ser_last` and no `abort`):
  - Register the `cmp_*` flags into `res_*`.
  - Register `res_error` = flags not exactly one-hot.
  - Set `res_valid` for the next cycle and return to IDLE.
- `abort` in SHIFT: return to IDLE next cycle; no capture, no `res_valid`. `abort` in IDLE is ignored.
- Simultaneous `abort` and `ser_last`: `abort` wins; there is no result.
- `in_valid` while `in_ready`=0 is ignored. Upstream holds its data; nothing is dropped.
- `res_less/eq/greater/error` hold their last captured value until the next capture.
- Counter width is $clog2(WIDTH). No wrap-around occurs, because the counter is reloaded on every accept.
- Async reset (`rst`=0) forces immediately, from any state including mid-shift:
  - state IDLE, shift registers 0, counter 0;
  - `in_ready`=1, `cmp_clear`=1, all `ser_*`=0;
  - `res_valid`=0, `res_less`=0, `res_eq`=1, `res_greater`=0, `res_error`=0.
- There is no downstream backpressure: the comparator consumes one bit pair per cycle unconditionally.

## Timing
- Accept on the edge that ends cycle T. The comparator sees `cmp_clear`=1 in cycle T, so it is cleared at that same edge.
- Bit cycles T+1 … T+WIDTH: `ser_first` at T+1, `ser_last` at T+WIDTH.
- Flags are captured at the edge ending T+WIDTH. `res_valid` is high in T+WIDTH+1.
- T+WIDTH+1 is an IDLE cycle, so a new accept is allowed in that cycle. Sustained throughput is one pair per WIDTH+1 cycles.
- Abort sampled in cycle T+k: IDLE from T+k+1, with `cmp_clear`=1 from that cycle.
- All outputs are functions of registered state only; there is no input-to-output combinational path.

## Structure
- Shared package `serial_compare_pkg`:
  - `state_e` enum (IDLE, SHIFT);
  - `cmp_result_t` packed struct {less, eq, greater, error};
  - reset constant `CMP_RESULT_RESET` = eq=1, others 0.
- One natural sub-module, `msb_first_shift_reg`:
  - parameter WIDTH;
  - parallel load, shift-left enable, MSB output;
  - instantiated twice, once for `a` and once for `b`.
- The FSM, counter and result capture live in the top module. The comparator itself is instantiated by the parent, not inside this block.

## Test plan
All scenarios use WIDTH=8, with a reference MSB-first comparator model attached to the `ser_*`/`cmp_*` ports.
- a=0xA5, b=0xA5, accept at T → `ser_a` = `ser_b` = 1,0,1,0,0,1,0,1 over T+1..T+8 → at T+9 `res_valid`=1, `res_eq`=1.
- a=0x80, b=0x7F → the first bit differs → `res_greater`=1; a=0x3C, b=0x3D → `res_less`=1 (decided only at the LSB).
- `in_valid` held high with two pairs → `in_ready` high at T and T+9 only; the second pair's `ser_first` is at T+10; `res_valid` at T+9 and T+18.
- `abort` at the 4th bit cycle (T+4) → `ser_valid`=0 and `cmp_clear`=1 at T+5, no `res_valid`, `in_ready`=1 at T+5. Repeat with `abort` on `ser_last` → no result.
- `rst`=0 mid-shift at T+3 → outputs take their reset values immediately (`res_eq`=1, `in_ready`=1). After release, a fresh pair compares correctly.
- Force `cmp_eq` and `cmp_greater` both to 1 on the LSB cycle → `res_error`=1 with `res_valid`. The next clean word → `res_error`=0.
